// File: rtl/param_register_file.sv
// Parameterised register file with two combinational read ports, one write port
// and a self-timed clear sweep that zeroes every register, one per cycle.
//
// Optional feature: define REGFILE_BYPASS_EN for write-to-read forwarding in IDLE.
//
// Parameters:
//   DATA_W   register width in bits
//   ADDR_W   address width; 2**ADDR_W registers
//   ZERO_REG when 1, register 0 reads as zero and ignores writes
// Ports:
//   clk_i               clock, all state updates on the rising edge
//   rst_i               synchronous active-high reset; starts a clear sweep
//   we_i/waddr_i/wdata_i  write port
//   raddr1_i/raddr2_i   read addresses
//   rdata1_o/rdata2_o   combinational read data (zero while busy)
//   clr_req_i           request a clear sweep
//   busy_o              high during every sweep cycle
//   clr_done_o          one-cycle pulse after the sweep completes
//   wr_drop_o           one-cycle pulse after a write arrived during a sweep
module param_register_file #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic              clr_req_i,
  output logic              busy_o,
  output logic              clr_done_o,
  output logic              wr_drop_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_done_q, clr_done_d;
  logic              wr_drop_q, wr_drop_d;

  logic [DATA_W-1:0] mem_q [Depth];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              user_we;

  // A user write that would actually land in storage (hard-zero register excluded).
  assign user_we = we_i && !(ZERO_REG && (waddr_i == '0));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    wr_drop_d  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = waddr_i;
    mem_wdata  = wdata_i;
    unique case (state_q)
      StIdle: begin
        // A same-cycle write still lands before the sweep begins.
        mem_we = user_we;
        if (clr_req_i) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + ADDR_W'(1);
        wr_drop_d = we_i;
        if (cnt_q == ADDR_W'(Depth - 1)) begin
          state_d    = StIdle;
          clr_done_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StClear;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_done_q <= clr_done_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  // Storage has no reset; reset only restarts the sweep.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    rdata1_o = mem_q[raddr1_i];
    rdata2_o = mem_q[raddr2_i];
`ifdef REGFILE_BYPASS_EN
    if (state_q == StIdle && user_we) begin
      if (raddr1_i == waddr_i) rdata1_o = wdata_i;
      if (raddr2_i == waddr_i) rdata2_o = wdata_i;
    end
`endif
    if (ZERO_REG && (raddr1_i == '0)) rdata1_o = '0;
    if (ZERO_REG && (raddr2_i == '0)) rdata2_o = '0;
    if (state_q == StClear) begin
      rdata1_o = '0;
      rdata2_o = '0;
    end
  end

  assign busy_o     = (state_q == StClear);
  assign clr_done_o = clr_done_q;
  assign wr_drop_o  = wr_drop_q;

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file (DATA_W=16, ADDR_W=3, ZERO_REG=1).
// A sweep-countdown model predicts every output each cycle; directed
// sequences add literal expectations.
module tb_param_register_file;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [2:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic [2:0]  raddr1 = '0;
  logic [2:0]  raddr2 = '0;
  logic        clr_req = 1'b0;
  logic [15:0] rdata1, rdata2;
  logic        busy, clr_done, wr_drop;

  int total = 0;
  int bad = 0;

  param_register_file #(
    .DATA_W  (16),
    .ADDR_W  (3),
    .ZERO_REG(1'b1)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr1_i  (raddr1),
    .raddr2_i  (raddr2),
    .rdata1_o  (rdata1),
    .rdata2_o  (rdata2),
    .clr_req_i (clr_req),
    .busy_o    (busy),
    .clr_done_o(clr_done),
    .wr_drop_o (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: contents plus the number of sweep cycles still to go.
  logic [15:0] m_mem [DEPTH];
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic        m_drop = 1'b0;
  bit          m_started = 1'b0;
  bit          m_inited = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left    <= DEPTH;
      m_done    <= 1'b0;
      m_drop    <= 1'b0;
      m_started <= 1'b1;
    end else if (m_left > 0) begin
      m_mem[DEPTH - m_left] <= '0;
      m_drop <= we;
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) m_inited <= 1'b1;
    end else begin
      if (we && waddr != 3'd0) m_mem[waddr] <= wdata;
      m_drop <= 1'b0;
      m_done <= 1'b0;
      if (clr_req) m_left <= DEPTH;
    end
  end

  function automatic logic [15:0] exp_rd(input logic [2:0] a);
    if (m_left > 0) return 16'h0;
    if (a == 3'd0) return 16'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && a == waddr) return wdata;
`endif
    return m_mem[a];
  endfunction

  always @(negedge clk) begin
    if (m_started) begin
      check("busy", 32'(busy), 32'(m_left > 0));
      check("clr_done", 32'(clr_done), 32'(m_done));
      check("wr_drop", 32'(wr_drop), 32'(m_drop));
      if (m_inited) begin
        check("rdata1", 32'(rdata1), 32'(exp_rd(raddr1)));
        check("rdata2", 32'(rdata2), 32'(exp_rd(raddr2)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int nb;
    int done_at;
    int done_cnt;
    int drop_at;

    // Reset for one edge, then watch the sweep.
    tick();
    rst = 1'b0;
    nb = 0;
    done_at = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (busy) nb++;
      if (clr_done) done_at = c;
    end
    check("rst_busy_cycles", 32'(nb), 32'd8);
    check("rst_done_cycle", 32'(done_at), 32'd9);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      raddr1 = 3'(i);
      raddr2 = 3'(DEPTH - 1 - i);
      @(negedge clk);
      check("rst_zero1", 32'(rdata1), 32'h0);
      check("rst_zero2", 32'(rdata2), 32'h0);
      tick();
    end

    // Plain write then dual read of the same address.
    we = 1'b1; waddr = 3'd5; wdata = 16'hBEEF;
    tick();
    we = 1'b0; raddr1 = 3'd5; raddr2 = 3'd5;
    @(negedge clk);
    check("beef1", 32'(rdata1), 32'hBEEF);
    check("beef2", 32'(rdata2), 32'hBEEF);
    tick();

    // Hard-zero register ignores writes.
    we = 1'b1; waddr = 3'd0; wdata = 16'h1234;
    tick();
    we = 1'b0; raddr1 = 3'd0; raddr2 = 3'd5;
    @(negedge clk);
    check("zero_reg", 32'(rdata1), 32'h0);
    check("distinct", 32'(rdata2), 32'hBEEF);
    tick();

    // Fill every register, read distinct pairs.
    for (int i = 1; i < DEPTH; i++) begin
      we = 1'b1; waddr = 3'(i); wdata = 16'(i * 16'h1357);
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      raddr1 = 3'(i);
      raddr2 = 3'(DEPTH - 1 - i);
      @(negedge clk);
      if (i == 3) check("fill_reg3", 32'(rdata1), 32'h3A05);
      tick();
    end

    // Clear request with a same-cycle write.
    we = 1'b1; waddr = 3'd3; wdata = 16'hA5A5;
    tick();
    we = 1'b0; raddr1 = 3'd3;
    @(negedge clk);
    check("a5a5", 32'(rdata1), 32'hA5A5);
    tick();
    we = 1'b1; waddr = 3'd4; wdata = 16'h1111; clr_req = 1'b1; raddr2 = 3'd4;
    tick();
    we = 1'b0; clr_req = 1'b0;
    nb = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (busy) begin
        nb++;
        if (rdata1 != 16'h0) check("busy_read", 32'(rdata1), 32'h0);
      end
      tick();
    end
    check("clr_busy_cycles", 32'(nb), 32'd8);
    @(negedge clk);
    check("clr_reg3", 32'(rdata1), 32'h0);
    check("clr_reg4", 32'(rdata2), 32'h0);
    tick();

    // Write and clear request during a sweep.
    we = 1'b1; waddr = 3'd2; wdata = 16'h2222;
    tick();
    we = 1'b0; clr_req = 1'b1;
    tick();
    nb = 0; drop_at = 0; done_at = 0;
    for (int c = 1; c <= 10; c++) begin
      clr_req = (c == 3);
      we = (c == 5); waddr = 3'd2; wdata = 16'h5555;
      raddr1 = 3'd2;
      @(negedge clk);
      if (busy) nb++;
      if (wr_drop) drop_at = c;
      if (clr_done) done_at = c;
      tick();
    end
    we = 1'b0; clr_req = 1'b0;
    check("drop_busy_cycles", 32'(nb), 32'd8);
    check("drop_cycle", 32'(drop_at), 32'd6);
    check("drop_done_cycle", 32'(done_at), 32'd9);
    @(negedge clk);
    check("drop_reg2", 32'(rdata1), 32'h0);
    tick();

    // Reset in the 4th sweep cycle restarts the sweep.
    we = 1'b1; waddr = 3'd7; wdata = 16'h7070;
    tick();
    we = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    nb = 0; done_cnt = 0; done_at = 0;
    for (int c = 1; c <= 14; c++) begin
      rst = (c == 4);
      @(negedge clk);
      if (busy) nb++;
      if (clr_done) begin
        done_cnt++;
        done_at = c;
      end
      tick();
    end
    rst = 1'b0;
    check("rst_mid_busy", 32'(nb), 32'd12);
    check("rst_mid_done_cnt", 32'(done_cnt), 32'd1);
    check("rst_mid_done_at", 32'(done_at), 32'd13);

    // Write-to-read forwarding.
    we = 1'b1; waddr = 3'd6; wdata = 16'h0F0F;
    tick();
    we = 1'b1; waddr = 3'd6; wdata = 16'h7777; raddr1 = 3'd6;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    check("bypass", 32'(rdata1), 32'h7777);
`else
    check("no_bypass", 32'(rdata1), 32'h0F0F);
`endif
    tick();
    we = 1'b0;
    @(negedge clk);
    check("after_write", 32'(rdata1), 32'h7777);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL provide parameter ZERO_REG, default 0; when 1, register 0 reads as zero and ignores writes.
REQ-004 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL provide port we  input  1  write enable.
REQ-007 SHALL provide port waddr  input  ADDR_W  write address.
REQ-008 SHALL provide port wdata  input  DATA_W  write data.
REQ-009 SHALL provide ports raddr1, raddr2  input  ADDR_W  read addresses.
REQ-010 SHALL provide ports rdata1, rdata2  output  DATA_W  read data, combinational from raddr.
REQ-011 SHALL provide port clr_req  input  1  request clear sweep of all registers.
REQ-012 SHALL provide port busy  output  1  high while clear sweep in progress.
REQ-013 SHALL provide port clr_done  output  1  one-cycle pulse at sweep completion.
REQ-014 SHALL provide port wr_drop  output  1  one-cycle pulse when a write is rejected.

Function
REQ-015 SHALL implement FSM states IDLE and CLEAR with a sweep counter cnt of ADDR_W bits.
REQ-016 In IDLE with we=1, SHALL write wdata to waddr at the rising edge (except waddr=0 when ZERO_REG=1).
REQ-017 In IDLE with clr_req=1, SHALL perform any same-cycle write, then enter CLEAR with cnt=0 at that edge.
REQ-018 In CLEAR, SHALL write zero to register cnt each cycle and increment cnt; registers zeroed in order 0..DEPTH-1.
REQ-019 In CLEAR with cnt=DEPTH-1, SHALL transition to IDLE and assert clr_done for exactly the following cycle.
REQ-020 Sweep SHALL occupy exactly DEPTH cycles; busy SHALL be high in every CLEAR cycle, low in IDLE.
REQ-021 In CLEAR, we=1 SHALL not modify storage and SHALL assert wr_drop the next cycle.
REQ-022 clr_req during CLEAR SHALL be ignored; sweep SHALL not restart.
REQ-023 While busy=1, rdata1 and rdata2 SHALL read zero.
REQ-024 In IDLE, rdataN SHALL equal register raddrN contents (zero for address 0 when ZERO_REG=1).
REQ-025 Both read ports SHALL allow same or distinct addresses concurrently without interaction.

Reset
REQ-026 rst=1 at a rising edge SHALL force state CLEAR, cnt=0, clr_done=0, wr_drop=0; storage unchanged that edge.
REQ-027 busy SHALL therefore be 1 in the cycle after reset; storage fully zero after DEPTH further cycles, then clr_done pulses.
REQ-028 rst asserted mid-sweep SHALL restart the sweep at cnt=0; rst takes priority over we and clr_req.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-030 With REGFILE_BYPASS_EN defined, in IDLE, we=1 and raddrN==waddr (and not the hard-zero register) SHALL drive rdataN=wdata combinationally.
REQ-031 Without REGFILE_BYPASS_EN, rdataN SHALL return the pre-write value until the edge completes.

Verification
REQ-032 Reset, DATA_W=16, ADDR_W=3: rst one cycle -> busy=1 for 8 cycles, clr_done=1 on 9th cycle after reset edge, all reads 0x0000.
REQ-033 IDLE write 0xBEEF to reg 5, then raddr1=5, raddr2=5 -> both rdata=0xBEEF; ZERO_REG=1 write 0x1234 to reg 0 -> reads 0x0000.
REQ-034 Write reg 3=0xA5A5, assert clr_req with we=1 waddr=4 data=0x1111 same cycle -> after 8 busy cycles reg 3 and reg 4 read 0x0000.
REQ-035 we=1 during CLEAR at waddr=2 -> wr_drop pulse next cycle, reg 2 reads 0x0000 after sweep.
REQ-036 rst at 4th sweep cycle -> busy stays high 8 more cycles, single clr_done pulse only at end.
REQ-037 Reg 6=0x0F0F, write 0x7777 to reg 6 with raddr1=6 same cycle -> rdata1=0x7777 with REGFILE_BYPASS_EN, 0x0F0F without.
